// File: rtl/traffic_ped_scheduler.sv
// Traffic-light phase scheduler for a main road, a side road and a pedestrian crossing.
// The one-hot phase register drives the lamps directly, so light is also the FSM state.
module traffic_ped_scheduler #(
    parameter int unsigned T_MG  = 8,
    parameter int unsigned T_Y   = 2,
    parameter int unsigned T_SG  = 5,
    parameter int unsigned T_PED = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       side_car,
    output logic [4:0] light,
    output logic       on,
    output logic       ped_wait,
    output logic       side_wait
);

    typedef enum logic [4:0] {
        MAIN_GREEN  = 5'b00001,
        MAIN_YELLOW = 5'b00010,
        SIDE_GREEN  = 5'b00100,
        SIDE_YELLOW = 5'b01000,
        PED_WALK    = 5'b10000
    } state_t;

    localparam logic [7:0] MG_LAST  = 8'(T_MG - 1);
    localparam logic [7:0] Y_LAST   = 8'(T_Y - 1);
    localparam logic [7:0] SG_LAST  = 8'(T_SG - 1);
    localparam logic [7:0] PED_LAST = 8'(T_PED - 1);

    state_t     state, state_nx;
    logic [7:0] timer, timer_nx;
    logic       ped_nx, side_nx;
    logic       entering;

    always_comb begin
        state_nx = state;
        case (state)
            MAIN_GREEN:
                if (timer == MG_LAST && (ped_wait || side_wait)) state_nx = MAIN_YELLOW;
            MAIN_YELLOW:
                if (timer == Y_LAST) begin
                    if (ped_wait)       state_nx = PED_WALK;
                    else if (side_wait) state_nx = SIDE_GREEN;
                    else                state_nx = MAIN_GREEN;
                end
            PED_WALK:
                if (timer == PED_LAST) begin
                    if (side_wait) state_nx = SIDE_GREEN;
                    else           state_nx = MAIN_GREEN;
                end
            SIDE_GREEN:
                if (timer == SG_LAST) state_nx = SIDE_YELLOW;
            SIDE_YELLOW:
                if (timer == Y_LAST) state_nx = MAIN_GREEN;
            default:
                state_nx = MAIN_GREEN;
        endcase
    end

    // Main green holds its timer at the minimum so it can wait for a request indefinitely.
    always_comb begin
        entering = (state_nx != state);
        timer_nx = timer + 8'd1;
        if (entering)
            timer_nx = 8'd0;
        else if (state == MAIN_GREEN && timer == MG_LAST)
            timer_nx = timer;

        // Clearing on the entry edge wins over a request sampled on that same edge.
        ped_nx  = ped_wait | ped_req;
        side_nx = side_wait | side_car;
        if (entering && state_nx == PED_WALK)   ped_nx  = 1'b0;
        if (entering && state_nx == SIDE_GREEN) side_nx = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MAIN_GREEN;
            timer     <= 8'd0;
            ped_wait  <= 1'b0;
            side_wait <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            ped_wait  <= ped_nx;
            side_wait <= side_nx;
        end
    end

    assign light = state;
    assign on    = light[4];

endmodule

// File: doc/traffic_ped_scheduler.md
TRAFFIC_PED_SCHEDULER -- requirements
Module: traffic_ped_scheduler

Interface
REQ-001 The block SHALL have parameter T_MG, default 8, minimum main-green dwell in cycles (legal range 1..255).
REQ-002 The block SHALL have parameter T_Y, default 2, yellow dwell in cycles, used for both main and side (1..255).
REQ-003 The block SHALL have parameter T_SG, default 5, side-green dwell in cycles (1..255).
REQ-004 The block SHALL have parameter T_PED, default 4, pedestrian-walk dwell in cycles (1..255).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port ped_req, input, 1 bit: pedestrian button; level or pulse, sampled every cycle.
REQ-008 The block SHALL have port side_car, input, 1 bit: side-road vehicle sensor, sampled every cycle.
REQ-009 The block SHALL have port light, output, 5 bits: one-hot phase, where bit0 = MAIN_GREEN, bit1 = MAIN_YELLOW, bit2 = SIDE_GREEN, bit3 = SIDE_YELLOW and bit4 = PED_WALK.
REQ-010 The block SHALL have port on, output, 1 bit: pedestrian walk indicator, equal to light[4].
REQ-011 The block SHALL have ports ped_wait and side_wait, outputs, 1 bit each: the latched pending-request flags.

Function
REQ-012 The block SHALL implement the five states MAIN_GREEN, MAIN_YELLOW, SIDE_GREEN, SIDE_YELLOW and PED_WALK, with light registered and exactly one-hot at all times.
REQ-013 The block SHALL use an 8-bit dwell timer that is cleared to 0 on every state entry and increments by 1 each cycle while in the state.
REQ-014 In MAIN_GREEN, the timer SHALL saturate at T_MG-1.
REQ-015 On the edge where ped_req=1, ped_wait SHALL be set; on the edge where side_car=1, side_wait SHALL be set.
REQ-016 Each wait flag SHALL be set regardless of the current state.
REQ-017 ped_wait SHALL be cleared on the edge entering PED_WALK, and side_wait SHALL be cleared on the edge entering SIDE_GREEN.
REQ-018 If set and clear coincide on the same edge, clear SHALL win, so a request asserted on the entry edge is lost.
REQ-019 In MAIN_GREEN, the block SHALL move to MAIN_YELLOW on the edge where timer == T_MG-1 and (ped_wait | side_wait) = 1; otherwise it SHALL remain in MAIN_GREEN indefinitely.
REQ-020 Wait flags decide transitions only in their registered form: a request sampled at edge E makes the exit no earlier than edge E+1.
REQ-021 MAIN_YELLOW SHALL last exactly T_Y cycles, then go to PED_WALK if ped_wait=1, else to SIDE_GREEN if side_wait=1, else to MAIN_GREEN.
REQ-022 PED_WALK SHALL last exactly T_PED cycles, then go to SIDE_GREEN if side_wait=1, else to MAIN_GREEN.
REQ-023 SIDE_GREEN SHALL last exactly T_SG cycles, then go to SIDE_YELLOW.
REQ-024 SIDE_YELLOW SHALL last exactly T_Y cycles, then go to MAIN_GREEN.
REQ-025 When both requests are pending at MAIN_YELLOW exit, pedestrian SHALL be served first, then side.
REQ-026 A ped_req during PED_WALK, or a side_car during SIDE_GREEN after the entry edge, SHALL re-latch and be served in a later cycle through MAIN_GREEN.
REQ-027 Timer arithmetic SHALL be unsigned with no wrap, since every phase exits before 255.

Reset
REQ-028 While rst=1 at a rising edge, the next state SHALL be MAIN_GREEN with light=5'b00001, on=0, ped_wait=0, side_wait=0 and timer=0.
REQ-029 Reset SHALL override all inputs, including a simultaneous ped_req or side_car.
REQ-030 Reset SHALL apply identically when asserted mid-phase.
REQ-031 After rst deasserts, MAIN_GREEN SHALL again observe the full T_MG minimum.

Verification
REQ-032 Idle scenario: rst high for 2 cycles, then 100 cycles with no requests -> light=00001 and on=0 throughout, and both wait flags stay 0.
REQ-033 Pedestrian-only scenario: ped_req pulsed for 1 cycle at cycle 20 after reset (edge E) -> ped_wait=1 after E, MAIN_YELLOW from E+1 for 2 cycles, PED_WALK with on=1 for 4 cycles, then MAIN_GREEN with ped_wait=0.
REQ-034 Minimum-green scenario: ped_req pulsed at cycle 2 after reset -> MAIN_GREEN still lasts exactly 8 cycles before MAIN_YELLOW.
REQ-035 Combined scenario: ped_req and side_car pulsed together in MAIN_GREEN -> sequence 00010 (2 cycles), 10000 (4), 00100 (5), 01000 (2), then 00001, with both flags cleared on their respective entries.
REQ-036 Reset-during-walk scenario: rst asserted for 1 cycle at walk cycle 2 -> the following cycle shows light=00001, on=0 and both flags 0, and the next exit takes at least 8 cycles.
REQ-037 Re-latch scenario: ped_req pulsed during PED_WALK -> ped_wait=1 after the walk ends, and a second walk follows after 8 cycles of MAIN_GREEN plus 2 cycles of yellow.
